// File: rtl/eth_rxstat_pkg.sv
// Shared definitions for the receive-status write-back block.
// Holds the write-back FSM state type, FIFO sizing and the bit layout of the
// 32-bit status word, plus a helper that packs a status word.
package eth_rxstat_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StGap
    } wbState_e;

    localparam int unsigned FifoDepth = 4;
    localparam int unsigned PtrWidth  = 2;
    localparam int unsigned CntWidth  = 3;

    // Status word bit positions
    localparam int unsigned BitByteCntHi = 31;
    localparam int unsigned BitByteCntLo = 16;
    localparam int unsigned BitCrcErr    = 8;
    localparam int unsigned BitDribble   = 7;
    localparam int unsigned BitTooBig    = 6;
    localparam int unsigned BitShort     = 5;
    localparam int unsigned BitInvSym    = 4;
    localparam int unsigned BitLateCol   = 3;
    localparam int unsigned BitMRxErr    = 2;
    localparam int unsigned BitOverrun   = 1;
    localparam int unsigned BitGood      = 0;

    // flags order: {crc, dribble, tooBig, short, invSym, lateCol, mrxErr}
    function automatic logic [31:0] packStatus(input logic [15:0] byteCnt,
                                               input logic [6:0]  flags,
                                               input logic        overrun);
        logic [31:0] w;
        w = '0;
        w[BitByteCntHi:BitByteCntLo] = byteCnt;
        w[BitCrcErr:BitMRxErr]       = flags;
        w[BitOverrun]                = overrun;
        w[BitGood]                   = ~|flags;
        return w;
    endfunction

endpackage

// File: rtl/eth_rxstatus_ctrl_if.sv
// Status write-back handshake bundle.
//   StatWrReq  : request, driven by the status controller
//   StatWrData : 32-bit status word, stable while StatWrReq=1
//   StatWrAck  : accept from the consumer, pops the entry
interface eth_rxstatus_ctrl_if;
    logic        StatWrReq;
    logic        StatWrAck;
    logic [31:0] StatWrData;

    modport master (output StatWrReq, output StatWrData, input StatWrAck);
    modport slave  (input StatWrReq, input StatWrData, output StatWrAck);
endinterface

// File: rtl/eth_rxstat_fifo.sv
// 4x32 status FIFO with wrapping 2-bit pointers.
//   MRxClk, Resetn : clock, async active-low reset (clears storage too)
//   push, wrData   : write request and word; ignored when full unless popping
//   pop            : read request; ignored when empty
//   rdData         : current head word
//   count, full, empty : occupancy
module eth_rxstat_fifo
    import eth_rxstat_pkg::*;
(
    input  logic                MRxClk,
    input  logic                Resetn,
    input  logic                push,
    input  logic                pop,
    input  logic [31:0]         wrData,
    output logic [31:0]         rdData,
    output logic [CntWidth-1:0] count,
    output logic                full,
    output logic                empty
);

    logic [31:0]         mem [FifoDepth];
    logic [PtrWidth-1:0] wrPtrQ, rdPtrQ;
    logic [CntWidth-1:0] cntQ;
    logic                doPush, doPop;

    assign full   = (cntQ == CntWidth'(FifoDepth));
    assign empty  = (cntQ == '0);
    assign doPop  = pop && !empty;
    // A pop in the same cycle frees the slot the full-FIFO push writes into.
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtrQ];
    assign count  = cntQ;

    always_ff @(posedge MRxClk or negedge Resetn) begin
        if (!Resetn) begin
            for (int unsigned i = 0; i < FifoDepth; i++) begin
                mem[i] <= '0;
            end
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            cntQ   <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtrQ] <= wrData;
                wrPtrQ      <= wrPtrQ + 1'b1;
            end
            if (doPop) begin
                rdPtrQ <= rdPtrQ + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   cntQ <= cntQ + 1'b1;
                2'b01:   cntQ <= cntQ - 1'b1;
                default: cntQ <= cntQ;
            endcase
        end
    end

endmodule

// File: rtl/eth_rxstatus_ctrl.sv
// Receive frame status queue and write-back controller.
// Each LoadRxStatus pulse packs the frame status into a 32-bit word and queues
// it in a 4-entry FIFO; a REQ/ACK handshake writes queued words back one by one.
//   MRxClk, Resetn        : clock, async active-low reset
//   LoadRxStatus          : one-cycle pulse, frame status valid
//   RxByteCnt, flag inputs: frame length and status flags
//   statWr                : write-back handshake (StatWrReq/StatWrData/StatWrAck)
//   StatOverrun/Clr       : sticky drop indicator and its clear (set wins)
//   StatCnt               : queued entries, 0..4
//   RxStatIrq/Clr         : interrupt and its clear; only built when the macro
//                           ETH_RXSTAT_IRQ_EN is defined, otherwise tied 0
module eth_rxstatus_ctrl
    import eth_rxstat_pkg::*;
(
    input  logic                MRxClk,
    input  logic                Resetn,
    input  logic                LoadRxStatus,
    input  logic [15:0]         RxByteCnt,
    input  logic                LatchedCrcError,
    input  logic                DribbleNibble,
    input  logic                ReceivedPacketTooBig,
    input  logic                ShortFrame,
    input  logic                InvalidSymbol,
    input  logic                RxLateCollision,
    input  logic                LatchedMRxErr,
    eth_rxstatus_ctrl_if.master statWr,
    output logic                StatOverrun,
    input  logic                StatOverrunClr,
    output logic [CntWidth-1:0] StatCnt,
    output logic                RxStatIrq,
    input  logic                RxStatIrqClr
);

    wbState_e    stateQ, stateD;
    logic [31:0] pushWord, headWord;
    logic        popReq, dropWord, fifoFull, fifoEmpty;
    logic        overrunQ, overrunD;

    assign pushWord = packStatus(RxByteCnt,
                                 {LatchedCrcError, DribbleNibble, ReceivedPacketTooBig,
                                  ShortFrame, InvalidSymbol, RxLateCollision, LatchedMRxErr},
                                 overrunQ);

    assign popReq   = (stateQ == StReq) && statWr.StatWrAck;
    assign dropWord = LoadRxStatus && fifoFull && !popReq;

    eth_rxstat_fifo u_fifo (
        .MRxClk (MRxClk),
        .Resetn (Resetn),
        .push   (LoadRxStatus),
        .pop    (popReq),
        .wrData (pushWord),
        .rdData (headWord),
        .count  (StatCnt),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    always_ff @(posedge MRxClk or negedge Resetn) begin
        if (!Resetn) begin
            stateQ   <= StIdle;
            overrunQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            overrunQ <= overrunD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        overrunD = overrunQ;
        if (dropWord) begin
            overrunD = 1'b1;
        end else if (StatOverrunClr) begin
            overrunD = 1'b0;
        end
        unique case (stateQ)
            // Looking at the incoming push gives the one-cycle request latency.
            StIdle:  if (!fifoEmpty || LoadRxStatus) stateD = StReq;
            StReq:   if (statWr.StatWrAck) stateD = StGap;
            StGap:   stateD = fifoEmpty ? StIdle : StReq;
            default: stateD = StIdle;
        endcase
    end

    assign statWr.StatWrReq  = (stateQ == StReq);
    assign statWr.StatWrData = headWord;
    assign StatOverrun       = overrunQ;

`ifdef ETH_RXSTAT_IRQ_EN
    logic irqQ, irqSet;

    assign irqSet = (popReq && !headWord[BitGood]) || dropWord;

    always_ff @(posedge MRxClk or negedge Resetn) begin
        if (!Resetn) begin
            irqQ <= 1'b0;
        end else if (irqSet) begin
            irqQ <= 1'b1;
        end else if (RxStatIrqClr) begin
            irqQ <= 1'b0;
        end
    end

    assign RxStatIrq = irqQ;
`else
    logic unusedIrqClr;
    assign unusedIrqClr = RxStatIrqClr;
    assign RxStatIrq    = 1'b0;
`endif

endmodule

// File: tb/tb_eth_rxstatus_ctrl.sv
module tb_eth_rxstatus_ctrl;

    logic        MRxClk = 1'b0;
    logic        Resetn;
    logic        LoadRxStatus;
    logic [15:0] RxByteCnt;
    logic [6:0]  frameFlags;
    logic        LatchedCrcError, DribbleNibble, ReceivedPacketTooBig, ShortFrame;
    logic        InvalidSymbol, RxLateCollision, LatchedMRxErr;
    logic        StatOverrun, StatOverrunClr, RxStatIrq, RxStatIrqClr;
    logic [2:0]  StatCnt;

    assign {LatchedCrcError, DribbleNibble, ReceivedPacketTooBig, ShortFrame,
            InvalidSymbol, RxLateCollision, LatchedMRxErr} = frameFlags;

    eth_rxstatus_ctrl_if wb ();

    eth_rxstatus_ctrl dut (
        .MRxClk               (MRxClk),
        .Resetn               (Resetn),
        .LoadRxStatus         (LoadRxStatus),
        .RxByteCnt            (RxByteCnt),
        .LatchedCrcError      (LatchedCrcError),
        .DribbleNibble        (DribbleNibble),
        .ReceivedPacketTooBig (ReceivedPacketTooBig),
        .ShortFrame           (ShortFrame),
        .InvalidSymbol        (InvalidSymbol),
        .RxLateCollision      (RxLateCollision),
        .LatchedMRxErr        (LatchedMRxErr),
        .statWr               (wb.master),
        .StatOverrun          (StatOverrun),
        .StatOverrunClr       (StatOverrunClr),
        .StatCnt              (StatCnt),
        .RxStatIrq            (RxStatIrq),
        .RxStatIrqClr         (RxStatIrqClr)
    );

    always #5 MRxClk = ~MRxClk;

    int vectors = 0;
    int miscompares = 0;

`ifdef ETH_RXSTAT_IRQ_EN
    localparam bit IrqOn = 1'b1;
`else
    localparam bit IrqOn = 1'b0;
`endif

    // Reference model: queue of pending words, sticky flags and handshake phase.
    logic [31:0] mQ[$];
    bit          mOv, mIrq;
    int          mPhase; // 0 waiting for work, 1 requesting, 2 one-cycle cooldown

    function automatic logic [31:0] expWord(input logic [15:0] len, input logic [6:0] fl,
                                            input bit ov);
        return 32'(len) * 32'h10000 + 32'(fl) * 4 + (ov ? 32'd2 : 32'd0)
               + ((fl == 7'd0) ? 32'd1 : 32'd0);
    endfunction

    task automatic modelReset();
        mQ.delete();
        mOv    = 1'b0;
        mIrq   = 1'b0;
        mPhase = 0;
    endtask

    function automatic logic [31:0] mHead();
        return (mQ.size() > 0) ? mQ[0] : 32'd0;
    endfunction

    // Advance one clock and the model; outputs are observed 1ns after the edge.
    task automatic step();
        int          sz, nPhase;
        bit          req, pop, drop, irqSet;
        logic [31:0] head, w;
        sz     = mQ.size();
        req    = (mPhase == 1);
        pop    = req && (wb.StatWrAck === 1'b1);
        head   = mHead();
        drop   = LoadRxStatus && (sz == 4) && !pop;
        w      = expWord(RxByteCnt, frameFlags, mOv);
        irqSet = IrqOn && ((pop && head[0] == 1'b0) || drop);
        case (mPhase)
            0:       nPhase = (sz != 0 || LoadRxStatus) ? 1 : 0;
            1:       nPhase = pop ? 2 : 1;
            default: nPhase = (sz != 0) ? 1 : 0;
        endcase
        @(posedge MRxClk);
        #1;
        if (pop) void'(mQ.pop_front());
        if (LoadRxStatus && !drop) mQ.push_back(w);
        mOv    = drop ? 1'b1 : (StatOverrunClr ? 1'b0 : mOv);
        mIrq   = irqSet ? 1'b1 : ((IrqOn && RxStatIrqClr) ? 1'b0 : mIrq);
        mPhase = nPhase;
    endtask

    task automatic idleInputs();
        LoadRxStatus   = 1'b0;
        wb.StatWrAck   = 1'b0;
        StatOverrunClr = 1'b0;
        RxStatIrqClr   = 1'b0;
    endtask

    task automatic setFrame(input logic [15:0] len, input logic [6:0] fl);
        RxByteCnt  = len;
        frameFlags = fl;
    endtask

    task automatic test_reset();
        idleInputs();
        setFrame(16'h0, 7'h0);
        Resetn = 1'b0;
        modelReset();
        #12;
        vectors++;
        if (wb.StatWrReq !== 1'b0 || wb.StatWrData !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_wb: req=%b data=%h required 0/00000000",
                     wb.StatWrReq, wb.StatWrData);
        end
        vectors++;
        if (StatCnt !== 3'd0 || StatOverrun !== 1'b0 || RxStatIrq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: cnt=%0d ov=%b irq=%b required 0/0/0",
                     StatCnt, StatOverrun, RxStatIrq);
        end
        #10 Resetn = 1'b1;
        @(posedge MRxClk);
        #1;
    endtask

    task automatic test_single_good();
        setFrame(16'd64, 7'h0);
        LoadRxStatus = 1'b1;
        step();
        LoadRxStatus = 1'b0;
        vectors++;
        if (wb.StatWrReq !== 1'b1 || wb.StatWrData !== 32'h0040_0001) begin
            miscompares++;
            $display("FAIL good_req: req=%b data=%h required 1/00400001",
                     wb.StatWrReq, wb.StatWrData);
        end
        wb.StatWrAck = 1'b1;
        step();
        wb.StatWrAck = 1'b0;
        vectors++;
        if (wb.StatWrReq !== 1'b0 || StatCnt !== 3'd0) begin
            miscompares++;
            $display("FAIL good_gap: req=%b cnt=%0d required 0/0", wb.StatWrReq, StatCnt);
        end
        step();
        step();
        vectors++;
        if (wb.StatWrReq !== 1'b0 || StatCnt !== 3'd0 || mPhase != 0) begin
            miscompares++;
            $display("FAIL good_idle: req=%b cnt=%0d required 0/0", wb.StatWrReq, StatCnt);
        end
    endtask

    task automatic test_crc_error();
        setFrame(16'd100, 7'b100_0000);
        LoadRxStatus = 1'b1;
        step();
        LoadRxStatus = 1'b0;
        vectors++;
        if (wb.StatWrReq !== 1'b1 || wb.StatWrData !== 32'h0064_0100) begin
            miscompares++;
            $display("FAIL crc_word: req=%b data=%h required 1/00640100",
                     wb.StatWrReq, wb.StatWrData);
        end
        wb.StatWrAck = 1'b1;
        step();
        wb.StatWrAck = 1'b0;
        vectors++;
        if (RxStatIrq !== IrqOn) begin
            miscompares++;
            $display("FAIL crc_irq: irq=%b required %b", RxStatIrq, IrqOn);
        end
        RxStatIrqClr = 1'b1;
        step();
        RxStatIrqClr = 1'b0;
        vectors++;
        if (RxStatIrq !== 1'b0) begin
            miscompares++;
            $display("FAIL crc_irq_clr: irq=%b required 0", RxStatIrq);
        end
        step();
    endtask

    task automatic test_overrun();
        logic [31:0] lastData;
        bit          sawLast;
        for (int i = 0; i < 5; i++) begin
            setFrame(16'($urandom), 7'($urandom));
            LoadRxStatus = 1'b1;
            step();
        end
        LoadRxStatus = 1'b0;
        vectors++;
        if (StatCnt !== 3'd4 || StatOverrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_full: cnt=%0d ov=%b required 4/1", StatCnt, StatOverrun);
        end
        vectors++;
        if (RxStatIrq !== IrqOn) begin
            miscompares++;
            $display("FAIL ovr_irq: irq=%b required %b", RxStatIrq, IrqOn);
        end
        wb.StatWrAck = 1'b1;
        step();
        wb.StatWrAck = 1'b0;
        setFrame(16'd1500, 7'h0);
        LoadRxStatus = 1'b1;
        step();
        LoadRxStatus = 1'b0;
        sawLast = 1'b0;
        lastData = '0;
        for (int c = 0; c < 30 && (mQ.size() > 0 || mPhase != 0); c++) begin
            wb.StatWrAck = 1'($urandom);
            vectors++;
            if (wb.StatWrReq !== (mPhase == 1)) begin
                miscompares++;
                $display("FAIL ovr_drain_req: req=%b required %b", wb.StatWrReq, mPhase == 1);
            end
            if (mPhase == 1) begin
                vectors++;
                if (wb.StatWrData !== mHead()) begin
                    miscompares++;
                    $display("FAIL ovr_drain_data: data=%h required %h",
                             wb.StatWrData, mHead());
                end
                lastData = wb.StatWrData;
                sawLast  = 1'b1;
            end
            step();
        end
        wb.StatWrAck = 1'b0;
        vectors++;
        if (!sawLast || lastData[1] !== 1'b1 || lastData[31:16] !== 16'd1500
            || StatCnt !== 3'd0) begin
            miscompares++;
            $display("FAIL ovr_next_word: data=%h cnt=%0d required 05dc0003 with cnt 0",
                     lastData, StatCnt);
        end
        StatOverrunClr = 1'b1;
        RxStatIrqClr   = 1'b1;
        step();
        idleInputs();
        vectors++;
        if (StatOverrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_clear: ov=%b required 0", StatOverrun);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            setFrame(16'(16'h100 + i), 7'($urandom_range(0, 1)));
            LoadRxStatus = 1'b1;
            step();
        end
        LoadRxStatus = 1'b0;
        vectors++;
        if (StatCnt !== 3'd4) begin
            miscompares++;
            $display("FAIL b2b_fill: cnt=%0d required 4", StatCnt);
        end
        // Push and pop together while full, enough times to wrap the pointers.
        for (int c = 0; c < 16; c++) begin
            if (mPhase == 1) begin
                setFrame(16'(16'h200 + c), 7'($urandom));
                LoadRxStatus = 1'b1;
                wb.StatWrAck = 1'b1;
                vectors++;
                if (wb.StatWrData !== mHead()) begin
                    miscompares++;
                    $display("FAIL b2b_order: data=%h required %h", wb.StatWrData, mHead());
                end
                step();
                vectors++;
                if (StatCnt !== 3'd4 || StatOverrun !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_hold: cnt=%0d ov=%b required 4/0", StatCnt, StatOverrun);
                end
            end else begin
                LoadRxStatus = 1'b0;
                wb.StatWrAck = 1'b0;
                step();
            end
        end
        LoadRxStatus = 1'b0;
        for (int c = 0; c < 30 && (mQ.size() > 0 || mPhase != 0); c++) begin
            wb.StatWrAck = 1'b1;
            if (mPhase == 1) begin
                vectors++;
                if (wb.StatWrReq !== 1'b1 || wb.StatWrData !== mHead()) begin
                    miscompares++;
                    $display("FAIL b2b_drain: req=%b data=%h required 1/%h",
                             wb.StatWrReq, wb.StatWrData, mHead());
                end
            end
            step();
        end
        RxStatIrqClr = 1'b1;
        step();
        idleInputs();
    endtask

    task automatic test_clear_race();
        for (int i = 0; i < 4; i++) begin
            setFrame(16'($urandom), 7'h0);
            LoadRxStatus = 1'b1;
            step();
        end
        StatOverrunClr = 1'b1;
        step();
        idleInputs();
        vectors++;
        if (StatOverrun !== 1'b1 || StatCnt !== 3'd4) begin
            miscompares++;
            $display("FAIL clear_race: ov=%b cnt=%0d required 1/4", StatOverrun, StatCnt);
        end
    endtask

    task automatic test_reset_mid_req();
        Resetn = 1'b0;
        #3 Resetn = 1'b1;
        modelReset();
        @(posedge MRxClk);
        #1;
        for (int i = 0; i < 3; i++) begin
            setFrame(16'($urandom), 7'($urandom));
            LoadRxStatus = 1'b1;
            step();
        end
        LoadRxStatus = 1'b0;
        vectors++;
        if (wb.StatWrReq !== 1'b1 || StatCnt !== 3'd3) begin
            miscompares++;
            $display("FAIL rst_mid_pre: req=%b cnt=%0d required 1/3", wb.StatWrReq, StatCnt);
        end
        #2 Resetn = 1'b0;
        modelReset();
        #1;
        vectors++;
        if (wb.StatWrReq !== 1'b0 || wb.StatWrData !== 32'd0 || StatCnt !== 3'd0
            || StatOverrun !== 1'b0 || RxStatIrq !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: req=%b data=%h cnt=%0d ov=%b irq=%b required zeros",
                     wb.StatWrReq, wb.StatWrData, StatCnt, StatOverrun, RxStatIrq);
        end
        @(posedge MRxClk);
        #1 Resetn = 1'b1;
        wb.StatWrAck = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if (wb.StatWrReq !== 1'b0 || StatCnt !== 3'd0) begin
                miscompares++;
                $display("FAIL rst_mid_after: req=%b cnt=%0d required 0/0",
                         wb.StatWrReq, StatCnt);
            end
        end
        wb.StatWrAck = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            LoadRxStatus   = ($urandom_range(0, 2) == 0);
            setFrame(16'($urandom), ($urandom_range(0, 1) == 1) ? 7'h0 : 7'($urandom));
            wb.StatWrAck   = 1'($urandom);
            StatOverrunClr = ($urandom_range(0, 9) == 0);
            RxStatIrqClr   = ($urandom_range(0, 5) == 0);
            step();
            vectors++;
            if (wb.StatWrReq !== (mPhase == 1) || StatCnt !== 3'(mQ.size())) begin
                miscompares++;
                $display("FAIL rand_flow: cyc=%0d req=%b cnt=%0d required %b/%0d",
                         c, wb.StatWrReq, StatCnt, mPhase == 1, mQ.size());
            end
            vectors++;
            if (StatOverrun !== mOv || RxStatIrq !== mIrq) begin
                miscompares++;
                $display("FAIL rand_flags: cyc=%0d ov=%b irq=%b required %b/%b",
                         c, StatOverrun, RxStatIrq, mOv, mIrq);
            end
            if (mPhase == 1) begin
                vectors++;
                if (wb.StatWrData !== mHead()) begin
                    miscompares++;
                    $display("FAIL rand_data: cyc=%0d data=%h required %h",
                             c, wb.StatWrData, mHead());
                end
            end
        end
        idleInputs();
    endtask

    initial begin
        test_reset();
        test_single_good();
        test_crc_error();
        test_overrun();
        test_back_to_back();
        test_clear_race();
        test_reset_mid_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
